pll_ctrl: RTL



---
 rtl/pll_ctrl_pkg.sv | 46 ++++
 rtl/pll_ctrl_lock_sync.sv | 24 ++
 rtl/pll_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and rPLL dynamic-select codes for the composite-video PLL sequencer.
// Select codes are in rPLL dynamic encoding (64 - divider).
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  typedef enum logic {
    MODE_NTSC = 1'b0,
    MODE_PAL  = 1'b1
  } mode_t;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_sel_t;

  // NTSC: IDIV 4, FBDIV 27, ODIV 8.  PAL: IDIV 5, FBDIV 34, ODIV 4.
  localparam logic [5:0] NTSC_IDSEL  = 6'd60;
  localparam logic [5:0] NTSC_FBDSEL = 6'd37;
  localparam logic [5:0] NTSC_ODSEL  = 6'd56;
  localparam logic [5:0] PAL_IDSEL   = 6'd59;
  localparam logic [5:0] PAL_FBDSEL  = 6'd30;
  localparam logic [5:0] PAL_ODSEL   = 6'd60;

  function automatic pll_sel_t mode_sel(mode_t m);
    pll_sel_t s;
    if (m == MODE_PAL) begin
      s.idsel  = PAL_IDSEL;
      s.fbdsel = PAL_FBDSEL;
      s.odsel  = PAL_ODSEL;
    end else begin
      s.idsel  = NTSC_IDSEL;
      s.fbdsel = NTSC_FBDSEL;
      s.odsel  = NTSC_ODSEL;
    end
    return s;
  endfunction

endpackage

// File: rtl/pll_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous rPLL LOCK into the clkin domain.
module pll_lock_sync (
  input  logic clkin,
  input  logic rst_n,
  input  logic pll_lock,
  output logic lock_s
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= pll_lock;
      sync_p1 <= meta_p0;
    end
  end

  assign lock_s = sync_p1;

endmodule

// File: rtl/pll_ctrl.sv
// rPLL reset/lock sequencer with run-time NTSC/PAL divider switching.
// Optional PLL_CTRL_LOCK_MON_EN: loss of lock in RUN forces a relock.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       cfg_valid,
  input  logic       cfg_mode,
  output logic       cfg_ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic       cur_mode
);

  localparam int MAX_A   = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

  logic             lock_s;
  state_t           state,   state_n;
  logic [CNT_W-1:0] cnt,     cnt_n;
  logic [RTY_W-1:0] retries, retries_n;
  mode_t            mode_q,  mode_n;
  pll_sel_t         sel;

  pll_lock_sync u_lock_sync (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .lock_s   (lock_s)
  );

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state   <= ST_HOLD;
      cnt     <= '0;
      retries <= '0;
      mode_q  <= MODE_NTSC;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      retries <= retries_n;
      mode_q  <= mode_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retries_n = retries;
    mode_n    = mode_q;
    unique case (state)
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
        end else if (cnt == TMO_LAST) begin
          cnt_n = '0;
          if (retries < RTY_MAX) begin
            retries_n = retries + RTY_W'(1);
            state_n   = ST_HOLD;
          end else begin
            state_n = ST_FAULT;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      // A lock dropout while qualifying only restarts the timeout; it is not a retry.
      ST_STABLE: begin
        if (!lock_s) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STB_LAST) begin
          state_n   = ST_RUN;
          cnt_n     = '0;
          retries_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (cfg_valid) begin
          mode_n  = mode_t'(cfg_mode);
          state_n = ST_HOLD;
          cnt_n   = '0;
        end
`ifdef PLL_CTRL_LOCK_MON_EN
        else if (!lock_s) begin
          state_n   = ST_HOLD;
          cnt_n     = '0;
          retries_n = '0;
        end
`endif
      end
      ST_FAULT: begin
        if (cfg_valid) begin
          mode_n    = mode_t'(cfg_mode);
          retries_n = '0;
          state_n   = ST_HOLD;
          cnt_n     = '0;
        end
      end
      default: begin
        state_n = ST_HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  // Selects follow mode_q, which only changes on the edge that enters HOLD.
  assign sel        = mode_sel(mode_q);
  assign pll_idsel  = sel.idsel;
  assign pll_fbdsel = sel.fbdsel;
  assign pll_odsel  = sel.odsel;

  assign pll_reset  = (state == ST_HOLD) || (state == ST_FAULT);
  assign sys_rst_n  = (state == ST_RUN);
  assign locked     = (state == ST_RUN);
  assign fault      = (state == ST_FAULT);
  assign cfg_ready  = (state == ST_RUN) || (state == ST_FAULT);
  assign cur_mode   = mode_q;

endmodule
